// File: rtl/score_sched.sv
// score_sched: issues NCAND candidates to score_cal and keeps the best returned score and its index.
// Optional SCORE_SCHED_THRESH_EN adds score_thresh/hit_cnt (count of returned scores >= threshold).
module score_sched #(
   parameter int width = 8,
   parameter int NCAND = 16,
   parameter int LAT   = 3,
   parameter int IDXW  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 cand_valid,
   input  logic [9*width-1:0]   cand_pts,
   output logic                 cand_ready,
   output logic [9*width-1:0]   point_val,
   input  logic [width+12:0]    score_in,
`ifdef SCORE_SCHED_THRESH_EN
   input  logic [width+12:0]    score_thresh,
   output logic [IDXW:0]        hit_cnt,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [width+12:0]    best_score,
   output logic [IDXW-1:0]      best_idx
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [IDXW-1:0]    IDX_ZERO   = {IDXW{1'b0}};
   localparam logic [IDXW-1:0]    IDX_LAST   = IDXW'(NCAND-1);
   localparam logic [IDXW-1:0]    IDX_ONE    = IDXW'(1'b1);
   localparam logic [LAT-1:0]     SR_ZERO    = {LAT{1'b0}};
   localparam logic [9*width-1:0] PTS_ZERO   = {(9*width){1'b0}};
   localparam logic [width+12:0]  SCORE_ZERO = {(width+13){1'b0}};

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [IDXW-1:0]  iss_cnt_r;
   logic [IDXW-1:0]  ret_cnt_r;
   logic             pv_vld_r;
   logic [LAT-1:0]   sr_r;
   logic [LAT-1:0]   sr_nxt_s;
   logic             xfer_s;
   logic             last_xfer_s;
   logic             begin_s;
   logic             ret_s;
   logic             better_s;

   // Index counters wrap only at NCAND.
   function automatic logic [IDXW-1:0] idx_inc(input logic [IDXW-1:0] v);
      if (v == IDX_LAST) begin
         return IDX_ZERO;
      end else begin
         return v + IDX_ONE;
      end
   endfunction

   // Handshake, pass start and return decode.
   always_comb begin
      xfer_s      = cand_valid & cand_ready;
      last_xfer_s = xfer_s & (iss_cnt_r == IDX_LAST);
      begin_s     = (state_r == IDLE) & start;
      ret_s       = sr_r[LAT-1];
      better_s    = (ret_cnt_r == IDX_ZERO) || (score_in > best_score);
   end

   // Next in-flight vector: the point_val tag enters, everything moves one stage toward the return tap.
   always_comb begin
      sr_nxt_s    = SR_ZERO;
      sr_nxt_s[0] = pv_vld_r;
      for (int i = 1; i < LAT; i++) begin
         sr_nxt_s[i] = sr_r[i-1];
      end
   end

   // Pass sequencing; DRAIN ends once the final return is being captured.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = ISSUE;
            else       state_nxt_s = IDLE;
         end
         ISSUE: begin
            if (last_xfer_s) state_nxt_s = DRAIN;
            else             state_nxt_s = ISSUE;
         end
         DRAIN: begin
            if (sr_nxt_s == SR_ZERO) state_nxt_s = DONE;
            else                     state_nxt_s = DRAIN;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         busy       <= 1'b0;
         cand_ready <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         busy       <= (state_nxt_s == ISSUE) || (state_nxt_s == DRAIN);
         cand_ready <= (state_nxt_s == ISSUE);
         done       <= (state_nxt_s == DONE);
      end
   end

   // Issue side: capture accepted candidate and track it through the score_cal latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         point_val <= PTS_ZERO;
         pv_vld_r  <= 1'b0;
         sr_r      <= SR_ZERO;
         iss_cnt_r <= IDX_ZERO;
      end else begin
         pv_vld_r <= xfer_s;
         sr_r     <= sr_nxt_s;
         if (xfer_s) begin
            point_val <= cand_pts;
         end
         if (begin_s) begin
            iss_cnt_r <= IDX_ZERO;
         end else if (xfer_s) begin
            iss_cnt_r <= idx_inc(iss_cnt_r);
         end
      end
   end

   // Return side: strict greater-than keeps the lower index on ties.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         best_score <= SCORE_ZERO;
         best_idx   <= IDX_ZERO;
         ret_cnt_r  <= IDX_ZERO;
      end else if (begin_s) begin
         best_score <= SCORE_ZERO;
         best_idx   <= IDX_ZERO;
         ret_cnt_r  <= IDX_ZERO;
      end else if (ret_s) begin
         if (better_s) begin
            best_score <= score_in;
            best_idx   <= ret_cnt_r;
         end
         ret_cnt_r <= idx_inc(ret_cnt_r);
      end
   end

`ifdef SCORE_SCHED_THRESH_EN
   localparam logic [IDXW:0] HIT_ZERO = {(IDXW+1){1'b0}};
   localparam logic [IDXW:0] HIT_ONE  = (IDXW+1)'(1'b1);

   // Count returned scores at or above the threshold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt <= HIT_ZERO;
      end else if (begin_s) begin
         hit_cnt <= HIT_ZERO;
      end else if (ret_s && (score_in >= score_thresh)) begin
         hit_cnt <= hit_cnt + HIT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_score_sched.sv
// Directed bench for score_sched with a 3-stage score_cal model (score = {in1, boundary}).
module tb_score_sched;
   localparam int W  = 8;
   localparam int NC = 16;
   localparam int L  = 3;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          cand_valid;
   logic [71:0]   cand_pts;
   logic          cand_ready;
   logic [71:0]   point_val;
   logic [20:0]   score_in;
   logic          busy;
   logic          done;
   logic [20:0]   best_score;
   logic [3:0]    best_idx;
`ifdef SCORE_SCHED_THRESH_EN
   logic [20:0]   score_thresh;
   logic [4:0]    hit_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   score_sched #(.width(W), .NCAND(NC), .LAT(L), .IDXW(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .cand_valid(cand_valid), .cand_pts(cand_pts),
      .cand_ready(cand_ready), .point_val(point_val), .score_in(score_in),
`ifdef SCORE_SCHED_THRESH_EN
      .score_thresh(score_thresh), .hit_cnt(hit_cnt),
`endif
      .busy(busy), .done(done), .best_score(best_score), .best_idx(best_idx)
   );

   always #5 clk = ~clk;

   // score_cal model: three register stages after point_val
   logic [20:0] pipe [0:2];
   initial begin
      for (int i = 0; i < 3; i++) pipe[i] = 21'd0;
   end
   always @(posedge clk) begin
      pipe[0] <= {5'd0, point_val[15:8], point_val[7:0]};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
   end
   assign score_in = pipe[2];

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // mode 0: boundary=10*k; mode 1: boundary=255; mode 2: 10*k with in1=1 (score 256) at k=7
   function automatic logic [71:0] mkvec(input int mode, input int k);
      logic [71:0] v;
      logic [31:0] r0, r1;
      r0 = $urandom;
      r1 = $urandom;
      v = {r0[23:0], r1, 16'h0000};
      if (mode == 1)                 v[15:0] = 16'h00ff;
      else if (mode == 2 && k == 7)  v[15:0] = 16'h0100;
      else                           v[15:0] = {8'h00, 8'(10*k)};
      return v;
   endfunction

   task automatic run_pass(input int mode, input int exp_cyc, input logic [20:0] exp_sc,
                           input logic [3:0] exp_ix, input int exp_hits, input int abort_at,
                           input logic extra_starts);
      int   k, n, done_at, ndone;
      logic v, xfer;
      k = 0; n = 0; done_at = -1;
      start = 1'b1; cand_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("best_cleared", best_score, 0);
      for (int guard = 0; guard < 100 && done_at < 0; guard++) begin
         v = (mode == 2) ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
         cand_valid = (k < NC) ? v : 1'b0;
         cand_pts = mkvec(mode, k);
         start = (extra_starts && (n == 5 || n == 15)) ? 1'b1 : 1'b0;
         xfer = cand_valid & cand_ready;
         @(posedge clk); #1;
         n++;
         if (xfer) begin
            k++;
            chk("point_val", point_val, cand_pts);
         end
         if (abort_at >= 0 && k == abort_at) begin
            rst = 1'b0; cand_valid = 1'b0; start = 1'b0;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_ready", cand_ready, 0);
            chk("abort_pv", point_val, 0);
            chk("abort_best", best_score, 0);
            repeat (2) @(posedge clk);
            #1; rst = 1'b1;
            ndone = 0;
            repeat (30) begin
               @(posedge clk); #1;
               if (done) ndone++;
            end
            chk("abort_no_done", ndone, 0);
            chk("abort_idle", busy, 0);
            return;
         end
         if (done) done_at = n;
      end
      cand_valid = 1'b0;
      chk("done_cycle", done_at, exp_cyc);
      chk("accepted", k, NC);
      chk("best_score", best_score, exp_sc);
      chk("best_idx", best_idx, exp_ix);
      chk("busy_at_done", busy, 0);
`ifdef SCORE_SCHED_THRESH_EN
      chk("hit_cnt", hit_cnt, exp_hits);
`endif
      start = extra_starts;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_one_cycle", done, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_done", busy, 0);
      chk("ready_after_done", cand_ready, 0);
      chk("best_hold", best_score, exp_sc);
      chk("idx_hold", best_idx, exp_ix);
   endtask

   initial begin
      logic [31:0] r;
      rst = 1'b0; start = 1'b0; cand_valid = 1'b0; cand_pts = 72'd0;
`ifdef SCORE_SCHED_THRESH_EN
      score_thresh = 21'd100;
`endif
      repeat (4) begin
         r = $urandom;
         start = r[0]; cand_valid = r[1];
         cand_pts = mkvec(0, 3);
         @(posedge clk); #1;
      end
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cand_ready, 0);
      chk("rst_pv", point_val, 0);
      chk("rst_best", best_score, 0);
      chk("rst_idx", best_idx, 0);
`ifdef SCORE_SCHED_THRESH_EN
      chk("rst_hits", hit_cnt, 0);
`endif
      start = 1'b0; cand_valid = 1'b1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_ready", cand_ready, 0);
      chk("idle_pv", point_val, 0);
      cand_valid = 1'b0;

      run_pass(0, 20, 21'd150, 4'd15, 6, -1, 1'b0);
      run_pass(1, 20, 21'd255, 4'd0, 16, -1, 1'b0);
      run_pass(2, 36, 21'd256, 4'd7, 7, -1, 1'b0);
      run_pass(0, 20, 21'd150, 4'd15, 6, -1, 1'b1);
      run_pass(0, 20, 21'd150, 4'd15, 6, 9, 1'b0);
      run_pass(0, 20, 21'd150, 4'd15, 6, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
